msrv32_writeback_unit: RTL and testbench
========================================

MSRV32_WRITEBACK_UNIT -- requirements
Module: msrv32_writeback_unit

Interface
REQ-001 SHALL have port ms_riscv32_mp_clk_in, input, 1, core clock; all state updates on its rising edge.
REQ-002 SHALL have port ms_riscv32_mp_rst_in, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port instr_valid_in, input, 1, a retiring instruction is presented this cycle.
REQ-004 SHALL have port rf_wr_req_in, input, 1, the instruction writes rd.
REQ-005 SHALL have port rd_addr_in, input, 5, destination register index.
REQ-006 SHALL have port wb_sel_in, input, 3, result source: 000 ALU, 001 LOAD, 010 IMM, 011 PC+4, 100 CSR; 101-111 treated as ALU.
REQ-007 SHALL have ports alu_result_in, imm_in, pc_plus_4_in and csr_data_in, each input, 32, the candidate results.
REQ-008 SHALL have ports load_size_in (input, 2: 00 byte, 01 half, 10 word), load_unsigned_in (input, 1) and load_addr_lsb_in (input, 2).
REQ-009 SHALL have ports dmem_rdata_in (input, 32) and dmem_rvalid_in (input, 1), the data-memory response.
REQ-010 SHALL have port rd_out, output, 32, register-file write data.
REQ-011 SHALL have port rd_addr_out, output, 5, register-file write index.
REQ-012 SHALL have port wr_en_out, output, 1, register-file write strobe.
REQ-013 SHALL have ports stall_out (output, 1, hold upstream) and misaligned_out (output, 1, one-cycle fault pulse).
REQ-014 SHALL have port timeout_out, output, 1, one-cycle load-abort pulse.

Function
REQ-015 SHALL implement states IDLE, WAIT_LOAD and COMMIT.
REQ-016 IDLE with instr_valid_in=1, rf_wr_req_in=1 and non-LOAD source SHALL register the selected source and rd_addr_in, then go to COMMIT; latency is 1 cycle to wr_en_out.
REQ-017 COMMIT SHALL assert wr_en_out for exactly one cycle, then return to IDLE; another instruction presented during COMMIT SHALL be accepted, with back-to-back commits allowed.
REQ-018 wr_en_out SHALL stay 0 whenever the latched rd_addr is 0, and the FSM sequencing SHALL remain unchanged.
REQ-019 A LOAD accepted in IDLE or COMMIT SHALL latch rd_addr, size, sign and lsb, then go to WAIT_LOAD.
REQ-020 stall_out SHALL be 1 combinationally in the LOAD accept cycle and throughout WAIT_LOAD, and 0 otherwise.
REQ-021 instr_valid_in SHALL be ignored while in WAIT_LOAD.
REQ-022 dmem_rvalid_in SHALL be sampled only in WAIT_LOAD; on rvalid=1 the unit SHALL extract, extend and go to COMMIT.
REQ-023 Extraction rules:
- byte: lane = lsb.
- half: lane = lsb[1].
- word: full data.
- Signed loads sign-extend; unsigned loads zero-extend to 32 bits.
REQ-024 Alignment rules:
- half with lsb[0]=1, or word with lsb!=00, SHALL be detected at accept.
- A detected load SHALL pulse misaligned_out for one cycle, perform no write and enter no WAIT_LOAD.
- load_size_in=11 SHALL be treated as misaligned.
REQ-025 instr_valid_in with rf_wr_req_in=0 SHALL cause no state change.

Reset
REQ-026 Reset asserted SHALL immediately force IDLE and the following outputs to 0: rd_out, rd_addr_out, wr_en_out, stall_out, misaligned_out, timeout_out.
REQ-027 Reset during WAIT_LOAD SHALL discard the pending load; a later dmem_rvalid_in SHALL be ignored.
REQ-028 Deassertion SHALL take effect on the next rising clock edge.

Configuration
REQ-029 With WB_LOAD_TIMEOUT_EN defined:
- An 8-bit counter SHALL clear on WAIT_LOAD entry and increment each WAIT_LOAD cycle.
- At count 255 without rvalid, the unit SHALL pulse timeout_out, perform no write, and return to IDLE.
- rvalid in the same cycle as count 255 SHALL win, and the load SHALL complete normally.
REQ-030 Without WB_LOAD_TIMEOUT_EN, WAIT_LOAD SHALL wait indefinitely and timeout_out SHALL be constant 0.

Verification
REQ-031 ALU: wb_sel=000, alu=32'h48484848, rd=2 -> next cycle wr_en_out=1, rd_addr_out=2, rd_out=32'h48484848, for 1 cycle.
REQ-032 Signed load byte: lsb=2, signed, rvalid after 3 cycles with rdata=32'h0080FF00 -> stall_out high 4 cycles; then rd_out=32'hFFFFFF80 and wr_en_out=1.
REQ-033 Unsigned load half: lsb=2, rdata=32'hBEEF1234 -> rd_out=32'h0000BEEF; signed variant -> rd_out=32'hFFFFBEEF.
REQ-034 x0 and misalign:
- rd=0, PC+4 source -> wr_en_out stays 0.
- word load, lsb=01 -> misaligned_out one pulse, no write, stall_out drops next cycle.
REQ-035 Reset and timeout:
- Reset asserted mid-WAIT_LOAD, then rvalid -> no write, all outputs 0.
- With WB_LOAD_TIMEOUT_EN and no rvalid -> timeout_out pulse 255 cycles after entry, no write.

Source files
------------

// File: rtl/msrv32_writeback_unit.sv
// msrv32_writeback_unit
// Writeback stage: selects the retiring result (ALU, LOAD, IMM, PC+4, CSR),
// extracts and extends load data, and issues a one-cycle register-file write.
// Optional build macro WB_LOAD_TIMEOUT_EN enables an abort of loads that
// receive no memory response within 256 WAIT_LOAD cycles.
module msrv32_writeback_unit (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        instr_valid_in,
    input  logic        rf_wr_req_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [2:0]  wb_sel_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic [31:0] csr_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [1:0]  load_addr_lsb_in,
    input  logic [31:0] dmem_rdata_in,
    input  logic        dmem_rvalid_in,
    output logic [31:0] rd_out,
    output logic [4:0]  rd_addr_out,
    output logic        wr_en_out,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic        timeout_out
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_LOAD = 2'd1;
    localparam logic [1:0] COMMIT    = 2'd2;

    localparam logic [2:0] SEL_LOAD = 3'b001;
    localparam logic [2:0] SEL_IMM  = 3'b010;
    localparam logic [2:0] SEL_PC4  = 3'b011;
    localparam logic [2:0] SEL_CSR  = 3'b100;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] rd_data_q;
    logic [4:0]  rd_addr_q;
    logic [1:0]  ld_size_q;
    logic        ld_unsigned_q;
    logic [1:0]  ld_lsb_q;
    logic        misaligned_q;

    logic        accept;
    logic        is_load;
    logic        load_accept;
    logic        misaligned_now;
    logic        load_start;
    logic        rvalid_hit;
    logic        timeout_hit;
    logic [31:0] sel_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    assign accept      = ((state == IDLE) || (state == COMMIT)) && instr_valid_in && rf_wr_req_in;
    assign is_load     = (wb_sel_in == SEL_LOAD);
    assign load_accept = accept && is_load;
    assign rvalid_hit  = (state == WAIT_LOAD) && dmem_rvalid_in;

    // Alignment check on the incoming load; size 11 is never a legal access
    always_comb begin
        misaligned_now = 1'b0;
        case (load_size_in)
            SIZE_BYTE: misaligned_now = 1'b0;
            SIZE_HALF: misaligned_now = load_addr_lsb_in[0];
            SIZE_WORD: misaligned_now = (load_addr_lsb_in != 2'b00);
            default:   misaligned_now = 1'b1;
        endcase
    end

    assign load_start = load_accept && !misaligned_now;

`ifdef WB_LOAD_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Counts WAIT_LOAD cycles; restarts at every new load entry
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            wait_cnt <= '0;
        end else if (load_start) begin
            wait_cnt <= '0;
        end else if (state == WAIT_LOAD) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // A response arriving on the last counted cycle takes priority over abort
    assign timeout_hit = (state == WAIT_LOAD) && (wait_cnt == 8'hFF) && !dmem_rvalid_in;
`else
    assign timeout_hit = 1'b0;
`endif

    // Non-load result source; reserved encodings fall back to the ALU
    always_comb begin
        sel_data = alu_result_in;
        case (wb_sel_in)
            SEL_IMM: sel_data = imm_in;
            SEL_PC4: sel_data = pc_plus_4_in;
            SEL_CSR: sel_data = csr_data_in;
            default: sel_data = alu_result_in;
        endcase
    end

    // Lane extraction and sign/zero extension of the memory response
    always_comb begin
        ld_byte = dmem_rdata_in[7:0];
        case (ld_lsb_q)
            2'd0: ld_byte = dmem_rdata_in[7:0];
            2'd1: ld_byte = dmem_rdata_in[15:8];
            2'd2: ld_byte = dmem_rdata_in[23:16];
            default: ld_byte = dmem_rdata_in[31:24];
        endcase
        ld_half = ld_lsb_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (ld_size_q)
            SIZE_BYTE: load_data = {{24{!ld_unsigned_q && ld_byte[7]}}, ld_byte};
            SIZE_HALF: load_data = {{16{!ld_unsigned_q && ld_half[15]}}, ld_half};
            default:   load_data = dmem_rdata_in;
        endcase
    end

    // Next-state: COMMIT overlaps acceptance of the following instruction
    always_comb begin
        state_next = state;
        case (state)
            IDLE, COMMIT: begin
                if (accept) begin
                    if (!is_load) begin
                        state_next = COMMIT;
                    end else if (misaligned_now) begin
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_LOAD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid_in) begin
                    state_next = COMMIT;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latched result/destination and load attributes
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state         <= IDLE;
            rd_data_q     <= '0;
            rd_addr_q     <= '0;
            ld_size_q     <= '0;
            ld_unsigned_q <= 1'b0;
            ld_lsb_q      <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state        <= state_next;
            misaligned_q <= load_accept && misaligned_now;
            if (accept && !is_load) begin
                rd_data_q <= sel_data;
                rd_addr_q <= rd_addr_in;
            end
            if (load_start) begin
                rd_addr_q     <= rd_addr_in;
                ld_size_q     <= load_size_in;
                ld_unsigned_q <= load_unsigned_in;
                ld_lsb_q      <= load_addr_lsb_in;
            end
            if (rvalid_hit) begin
                rd_data_q <= load_data;
            end
        end
    end

    assign rd_out         = rd_data_q;
    assign rd_addr_out    = rd_addr_q;
    assign wr_en_out      = (state == COMMIT) && (rd_addr_q != 5'd0);
    assign stall_out      = ms_riscv32_mp_rst_in && (load_accept || (state == WAIT_LOAD));
    assign misaligned_out = misaligned_q;
    assign timeout_out    = timeout_hit;

endmodule

// File: tb/tb_msrv32_writeback_unit.sv
// tb_msrv32_writeback_unit
// Directed stimulus; each driver task records the outputs it requires per
// cycle in expectation tables, and one negedge process compares the DUT.
module tb_msrv32_writeback_unit;

    localparam int unsigned NCYC = 4096;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        rf_wr_req;
    logic [4:0]  rd_addr;
    logic [2:0]  wb_sel;
    logic [31:0] alu_result;
    logic [31:0] imm;
    logic [31:0] pc_plus_4;
    logic [31:0] csr_data;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [1:0]  load_lsb;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic [31:0] rd_out;
    logic [4:0]  rd_addr_out;
    logic        wr_en_out;
    logic        stall_out;
    logic        misaligned_out;
    logic        timeout_out;

    msrv32_writeback_unit dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .instr_valid_in       (instr_valid),
        .rf_wr_req_in         (rf_wr_req),
        .rd_addr_in           (rd_addr),
        .wb_sel_in            (wb_sel),
        .alu_result_in        (alu_result),
        .imm_in               (imm),
        .pc_plus_4_in         (pc_plus_4),
        .csr_data_in          (csr_data),
        .load_size_in         (load_size),
        .load_unsigned_in     (load_unsigned),
        .load_addr_lsb_in     (load_lsb),
        .dmem_rdata_in        (dmem_rdata),
        .dmem_rvalid_in       (dmem_rvalid),
        .rd_out               (rd_out),
        .rd_addr_out          (rd_addr_out),
        .wr_en_out            (wr_en_out),
        .stall_out            (stall_out),
        .misaligned_out       (misaligned_out),
        .timeout_out          (timeout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation tables indexed by cycle number
    logic        exp_stall [NCYC];
    logic        exp_wr    [NCYC];
    logic        exp_mis   [NCYC];
    logic        exp_to    [NCYC];
    logic        exp_zero  [NCYC];
    logic [31:0] exp_data  [NCYC];
    logic [4:0]  exp_addr  [NCYC];

    int n_cmp = 0;
    int n_bad = 0;
    logic checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Single compare process, sampled away from the rising edge
    always @(negedge clk) begin
        if (checking && cyc >= 1 && cyc < NCYC) begin
            check("stall", {31'd0, stall_out}, {31'd0, exp_stall[cyc]});
            check("wr_en", {31'd0, wr_en_out}, {31'd0, exp_wr[cyc]});
            check("misaligned", {31'd0, misaligned_out}, {31'd0, exp_mis[cyc]});
            check("timeout", {31'd0, timeout_out}, {31'd0, exp_to[cyc]});
            if (exp_wr[cyc]) begin
                check("rd_data", rd_out, exp_data[cyc]);
                check("rd_addr", {27'd0, rd_addr_out}, {27'd0, exp_addr[cyc]});
            end
            if (exp_zero[cyc]) begin
                check("rst_rd_data", rd_out, 32'd0);
                check("rst_rd_addr", {27'd0, rd_addr_out}, 32'd0);
            end
        end
    end

    // Reference: result source selection
    function automatic logic [31:0] src_model(input logic [2:0] sel, input logic [31:0] a,
                                              input logic [31:0] i, input logic [31:0] p,
                                              input logic [31:0] c);
        if (sel == 3'd2) return i;
        if (sel == 3'd3) return p;
        if (sel == 3'd4) return c;
        return a;
    endfunction

    // Reference: load value by shifting and masking arithmetic
    function automatic logic [31:0] load_model(input logic [1:0] size, input logic uns,
                                               input logic [1:0] lsb, input logic [31:0] d);
        int unsigned v;
        if (size == 2'd2) return d;
        if (size == 2'd0) begin
            v = (d >> (8 * lsb)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else begin
            v = (d >> (16 * lsb[1])) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lsb);
        int unsigned bytes;
        if (size == 2'd3) return 1'b1;
        bytes = 1 << size;
        return (lsb % bytes) != 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        rf_wr_req   = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
    endtask

    task automatic expect_write(input int c, input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0 && c < NCYC) begin
            exp_wr[c]   = 1'b1;
            exp_data[c] = v;
            exp_addr[c] = rd;
        end
    endtask

    task automatic issue_reg(input logic [2:0] sel, input logic [4:0] rd, input logic [31:0] a,
                             input logic [31:0] i, input logic [31:0] p, input logic [31:0] c,
                             input logic [31:0] expv);
        step();
        instr_valid = 1'b1;
        rf_wr_req   = 1'b1;
        wb_sel      = sel;
        rd_addr     = rd;
        alu_result  = a;
        imm         = i;
        pc_plus_4   = p;
        csr_data    = c;
        expect_write(cyc + 1, rd, expv);
    endtask

    task automatic issue_load(input logic [1:0] size, input logic uns, input logic [1:0] lsb,
                              input logic [4:0] rd, input int wait_n, input logic [31:0] rdata,
                              input logic [31:0] expv);
        int c;
        step();
        instr_valid   = 1'b1;
        rf_wr_req     = 1'b1;
        wb_sel        = 3'b001;
        rd_addr       = rd;
        load_size     = size;
        load_unsigned = uns;
        load_lsb      = lsb;
        dmem_rvalid   = 1'b1;
        dmem_rdata    = 32'hDEADBEEF;
        c = cyc;
        exp_stall[c] = 1'b1;
        if (bad_align(size, lsb)) begin
            exp_mis[c + 1] = 1'b1;
        end else begin
            for (int k = 1; k <= wait_n; k++) begin
                step();
                if (cyc < NCYC) exp_stall[cyc] = 1'b1;
                if (k == 1) begin
                    instr_valid = 1'b1;
                    rf_wr_req   = 1'b1;
                    wb_sel      = 3'b000;
                    rd_addr     = 5'd7;
                    alu_result  = 32'h0BAD0BAD;
                end
                if (k == wait_n) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                end
            end
            expect_write(c + wait_n + 1, rd, expv);
        end
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_stall[i] = 1'b0; exp_wr[i] = 1'b0; exp_mis[i] = 1'b0;
            exp_to[i] = 1'b0; exp_zero[i] = 1'b0; exp_data[i] = '0; exp_addr[i] = '0;
        end
        rst_n = 1'b0;
        instr_valid = 1'b0; rf_wr_req = 1'b0; rd_addr = '0; wb_sel = '0;
        alu_result = '0; imm = '0; pc_plus_4 = '0; csr_data = '0;
        load_size = '0; load_unsigned = 1'b0; load_lsb = '0;
        dmem_rdata = '0; dmem_rvalid = 1'b0;
        checking = 1'b1;

        // Reset: outputs zero even with a load presented
        for (int i = 0; i < 4; i++) begin
            step();
            exp_zero[cyc] = 1'b1;
            if (i == 2) begin
                instr_valid = 1'b1; rf_wr_req = 1'b1; wb_sel = 3'b001;
                load_size = 2'b10; load_lsb = 2'b00; rd_addr = 5'd3;
            end
        end
        step();
        rst_n = 1'b1;
        exp_zero[cyc] = 1'b1;

        // Register sources, back-to-back commits, reserved select encoding
        issue_reg(3'b000, 5'd2, 32'h48484848, 32'h1, 32'h2, 32'h3, 32'h48484848);
        step();
        issue_reg(3'b010, 5'd3, 32'hA, 32'h11111111, 32'h22222222, 32'h33333333, 32'h11111111);
        issue_reg(3'b011, 5'd4, 32'hA, 32'h11111111, 32'h22222222, 32'h33333333, 32'h22222222);
        issue_reg(3'b100, 5'd5, 32'hA, 32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333);
        issue_reg(3'b110, 5'd6, 32'h5A5A5A5A, 32'h1, 32'h2, 32'h3,
                  src_model(3'b110, 32'h5A5A5A5A, 32'h1, 32'h2, 32'h3));
        issue_reg(3'b111, 5'd31, 32'hFFFFFFFF, 32'h1, 32'h2, 32'h3, 32'hFFFFFFFF);
        issue_reg(3'b011, 5'd0, 32'h0, 32'h0, 32'h00001004, 32'h0, 32'h00001004);
        step();

        // No write request: neither a register source nor a load acts
        step();
        instr_valid = 1'b1; rf_wr_req = 1'b0; wb_sel = 3'b000; rd_addr = 5'd8;
        step();
        instr_valid = 1'b1; rf_wr_req = 1'b0; wb_sel = 3'b001; rd_addr = 5'd8;
        load_size = 2'b10; load_lsb = 2'b00;
        step();

        // Loads: literal-pinned vectors then model-derived ones
        issue_load(2'b00, 1'b0, 2'd2, 5'd10, 3, 32'h0080FF00, 32'hFFFFFF80);
        issue_load(2'b01, 1'b1, 2'd2, 5'd11, 1, 32'hBEEF1234, 32'h0000BEEF);
        issue_load(2'b01, 1'b0, 2'd2, 5'd12, 2, 32'hBEEF1234, 32'hFFFFBEEF);
        issue_load(2'b10, 1'b0, 2'd0, 5'd13, 1, 32'hCAFEF00D, load_model(2'b10, 1'b0, 2'd0, 32'hCAFEF00D));
        issue_load(2'b00, 1'b1, 2'd3, 5'd14, 2, 32'h80563412, load_model(2'b00, 1'b1, 2'd3, 32'h80563412));
        issue_load(2'b00, 1'b0, 2'd1, 5'd15, 1, 32'h12347F56, load_model(2'b00, 1'b0, 2'd1, 32'h12347F56));
        issue_load(2'b01, 1'b0, 2'd0, 5'd16, 1, 32'h00008001, load_model(2'b01, 1'b0, 2'd0, 32'h00008001));
        issue_load(2'b10, 1'b0, 2'd0, 5'd0, 1, 32'h12345678, 32'h12345678);
        step();

        // Load accepted while a commit is in progress
        issue_reg(3'b000, 5'd17, 32'h01020304, 32'h0, 32'h0, 32'h0, 32'h01020304);
        issue_load(2'b10, 1'b0, 2'd0, 5'd18, 2, 32'h55AA55AA, 32'h55AA55AA);
        issue_reg(3'b010, 5'd19, 32'h0, 32'h77777777, 32'h0, 32'h0, 32'h77777777);
        step();

        // Misaligned accesses: pulse, no write, stall only in accept cycle
        issue_load(2'b10, 1'b0, 2'd1, 5'd20, 1, 32'h0, 32'h0);
        step();
        issue_load(2'b10, 1'b0, 2'd2, 5'd20, 1, 32'h0, 32'h0);
        step();
        issue_load(2'b01, 1'b0, 2'd1, 5'd20, 1, 32'h0, 32'h0);
        step();
        issue_load(2'b01, 1'b1, 2'd3, 5'd20, 1, 32'h0, 32'h0);
        step();
        issue_load(2'b11, 1'b0, 2'd0, 5'd20, 1, 32'h0, 32'h0);
        issue_reg(3'b000, 5'd21, 32'h0000ABCD, 32'h0, 32'h0, 32'h0, 32'h0000ABCD);
        step();

        // Reset while a load is pending; the late response must be dropped
        step();
        instr_valid = 1'b1; rf_wr_req = 1'b1; wb_sel = 3'b001; rd_addr = 5'd22;
        load_size = 2'b10; load_lsb = 2'b00;
        exp_stall[cyc] = 1'b1;
        step();
        exp_stall[cyc] = 1'b1;
        step();
        rst_n = 1'b0;
        exp_zero[cyc] = 1'b1;
        step();
        rst_n = 1'b1;
        exp_zero[cyc] = 1'b1;
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h99999999;
        exp_zero[cyc] = 1'b1;
        step();
        exp_zero[cyc] = 1'b1;
        step();

`ifdef WB_LOAD_TIMEOUT_EN
        // Abort after 256 silent WAIT_LOAD cycles
        begin
            int c;
            step();
            instr_valid = 1'b1; rf_wr_req = 1'b1; wb_sel = 3'b001; rd_addr = 5'd23;
            load_size = 2'b10; load_lsb = 2'b00;
            c = cyc;
            exp_stall[c] = 1'b1;
            for (int k = 1; k <= 256; k++) begin
                step();
                exp_stall[cyc] = 1'b1;
            end
            exp_to[c + 256] = 1'b1;
            step();
            step();
        end
        // Response on the final counted cycle completes normally
        issue_load(2'b10, 1'b0, 2'd0, 5'd24, 256, 32'h13579BDF, 32'h13579BDF);
        step();
`else
        // Without the abort feature a long wait still completes
        issue_load(2'b10, 1'b0, 2'd0, 5'd24, 300, 32'h13579BDF, 32'h13579BDF);
        step();
`endif

        step();
        step();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
